mac_array_sched: RTL

//  Sequencer for the 32-filter MAC array. Walks filter-group x output-pixel x channel-group loops.

---
 rtl/mac_sched_pkg.sv | 26 ++
 rtl/mac_sched_tag_fifo.sv | 57 +++++
 rtl/mac_array_sched.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_sched_pkg.sv
// Shared types for the MAC array scheduler: FSM states, result tag layout, array width.
// Latency: n/a (types only).
// Backpressure: n/a.
package mac_sched_pkg;

    localparam int MAC_FILTERS = 32;
    localparam int TAG_PIX_W   = 16;
    localparam int TAG_FG_W    = 4;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        FIN,
        ERR
    } state_t;

    // One completed MAC_FILTERS-wide partial result awaiting write-back
    typedef struct packed {
        logic [TAG_PIX_W-1:0] pix;
        logic [TAG_FG_W-1:0]  fg;
    } tag_t;

    localparam int TAG_W = $bits(tag_t);

endpackage

// File: rtl/mac_sched_tag_fifo.sv
// Synchronous FIFO of in-flight pixel tags, DEPTH a power of two (>= 2), with occupancy count.
// Latency: pushed tag visible at head the cycle after push; head is read combinationally.
// Backpressure: push on full is dropped unless a pop happens the same cycle; pop on empty ignored.
import mac_sched_pkg::*;

module mac_sched_tag_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [TAG_W-1:0]           push_dat,
    input  logic                       pop,
    output logic [TAG_W-1:0]           pop_dat,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

    tag_t          mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL) || do_pop);
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= tag_t'(push_dat);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mac_array_sched.sv
// MAC array sequencer: walks fg > pix > cg loops, issues operand reads, tags finished pixels.
// Latency: strobes reach the array RD_LAT cycles after rd_req&rd_gnt; done two cycles after the last tag retires.
// Backpressure: rd_gnt low stalls in place; full tag window drops rd_req; res_ready low holds the result. MAC_SCHED_PERF_EN adds perf counters.
import mac_sched_pkg::*;

module mac_array_sched #(
    parameter int CG_W      = 8,
    parameter int PIX_W     = 16,
    parameter int FG_W      = 4,
    parameter int ADDR_W    = 20,
    parameter int RD_LAT    = 2,
    parameter int TAG_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CG_W-1:0]   cfg_num_cg,
    input  logic [PIX_W-1:0]  cfg_num_pix,
    input  logic [FG_W-1:0]   cfg_num_fg,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err_cfg,
    output logic              err_ovf,
    output logic              rd_req,
    input  logic              rd_gnt,
    output logic [ADDR_W-1:0] rd_addr_din,
    output logic [ADDR_W-1:0] rd_addr_wgt,
    output logic              mac_vld,
    output logic              mac_first,
    output logic              mac_last,
    input  logic              acc_done,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [PIX_W-1:0]  res_pix,
    output logic [FG_W-1:0]   res_fg
`ifdef MAC_SCHED_PERF_EN
    ,
    output logic [31:0]       perf_busy_cyc,
    output logic [31:0]       perf_stall_cyc
`endif
);

    typedef struct packed {
        logic             vld;
        logic             first;
        logic             last;
        logic [PIX_W-1:0] pix;
        logic [FG_W-1:0]  fg;
    } strb_t;

    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    state_t            state;
    state_t            state_nxt;
    logic [CG_W-1:0]   num_cg;
    logic [CG_W-1:0]   cg_cnt;
    logic [PIX_W-1:0]  num_pix;
    logic [PIX_W-1:0]  pix_cnt;
    logic [FG_W-1:0]   num_fg;
    logic [FG_W-1:0]   fg_cnt;
    logic [ADDR_W-1:0] wgt_base;
    strb_t             pipe [RD_LAT];
    logic [CNT_W-1:0]  tag_count;
    tag_t              push_tag;
    tag_t              head_tag;
    logic [TAG_W-1:0]  head_vec;
    logic              start_acc;
    logic              cfg_zero;
    logic              accept;
    logic              cg_wrap;
    logic              pix_wrap;
    logic              fg_wrap;
    logic              last_rd;
    logic              tag_full;
    logic              tag_stall;
    logic              tag_push;
    logic              tag_pop;
    logic              pipe_any;
    int                pipe_pix;

    assign cfg_zero  = (cfg_num_cg == '0) || (cfg_num_pix == '0) || (cfg_num_fg == '0);
    assign start_acc = (state == IDLE) && start;
    assign accept    = rd_req && rd_gnt;
    assign cg_wrap   = (cg_cnt == num_cg - CG_W'(1));
    assign pix_wrap  = (pix_cnt == num_pix - PIX_W'(1));
    assign fg_wrap   = (fg_cnt == num_fg - FG_W'(1));
    assign last_rd   = cg_wrap && pix_wrap && fg_wrap;

    // Pixels whose last read is still in the strobe pipe count against the tag window
    always_comb begin
        pipe_pix = 0;
        pipe_any = 1'b0;
        for (int i = 0; i < RD_LAT; i++) begin
            if (pipe[i].vld) begin
                pipe_any = 1'b1;
            end
            if (pipe[i].vld && pipe[i].last) begin
                pipe_pix = pipe_pix + 1;
            end
        end
    end

    assign tag_full  = (int'(tag_count) + pipe_pix) >= TAG_DEPTH;
    assign tag_stall = (state == ISSUE) && (cg_cnt == '0) && tag_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        rd_req    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = cfg_zero ? ERR : ISSUE;
                end
            end
            ISSUE: begin
                busy   = 1'b1;
                rd_req = !tag_stall;
                if (rd_gnt && !tag_stall && last_rd) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if ((tag_count == '0) && !res_valid && !pipe_any) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ERR: begin
                busy      = 1'b1;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Feature address runs linearly within a filter group; weights rewind to wgt_base per pixel
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            num_cg      <= '0;
            num_pix     <= '0;
            num_fg      <= '0;
            cg_cnt      <= '0;
            pix_cnt     <= '0;
            fg_cnt      <= '0;
            wgt_base    <= '0;
            rd_addr_din <= '0;
            rd_addr_wgt <= '0;
            err_cfg     <= 1'b0;
        end else if (start_acc) begin
            num_cg      <= cfg_num_cg;
            num_pix     <= cfg_num_pix;
            num_fg      <= cfg_num_fg;
            cg_cnt      <= '0;
            pix_cnt     <= '0;
            fg_cnt      <= '0;
            wgt_base    <= '0;
            rd_addr_din <= '0;
            rd_addr_wgt <= '0;
            err_cfg     <= cfg_zero;
        end else if (accept) begin
            if (!cg_wrap) begin
                cg_cnt      <= cg_cnt + CG_W'(1);
                rd_addr_din <= rd_addr_din + ADDR_W'(1);
                rd_addr_wgt <= rd_addr_wgt + ADDR_W'(1);
            end else begin
                cg_cnt <= '0;
                if (!pix_wrap) begin
                    pix_cnt     <= pix_cnt + PIX_W'(1);
                    rd_addr_din <= rd_addr_din + ADDR_W'(1);
                    rd_addr_wgt <= wgt_base;
                end else if (!fg_wrap) begin
                    pix_cnt     <= '0;
                    fg_cnt      <= fg_cnt + FG_W'(1);
                    rd_addr_din <= '0;
                    wgt_base    <= wgt_base + ADDR_W'(num_cg);
                    rd_addr_wgt <= wgt_base + ADDR_W'(num_cg);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0].vld   <= accept;
            pipe[0].first <= accept && (cg_cnt == '0);
            pipe[0].last  <= accept && cg_wrap;
            pipe[0].pix   <= pix_cnt;
            pipe[0].fg    <= fg_cnt;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign mac_vld   = pipe[RD_LAT-1].vld;
    assign mac_first = pipe[RD_LAT-1].first;
    assign mac_last  = pipe[RD_LAT-1].last;
    assign tag_push  = pipe[RD_LAT-1].vld && pipe[RD_LAT-1].last;
    assign push_tag  = {TAG_PIX_W'(pipe[RD_LAT-1].pix), TAG_FG_W'(pipe[RD_LAT-1].fg)};
    assign tag_pop   = acc_done && (tag_count != '0);
    assign head_tag  = tag_t'(head_vec);

    mac_sched_tag_fifo #(
        .DEPTH    (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (tag_push),
        .push_dat (push_tag),
        .pop      (acc_done),
        .pop_dat  (head_vec),
        .count    (tag_count)
    );

    // A pop while the previous result is still held loses the popped tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_pix   <= '0;
            res_fg    <= '0;
            err_ovf   <= 1'b0;
        end else begin
            if (start_acc) begin
                err_ovf <= 1'b0;
            end
            if (tag_pop) begin
                if (res_valid && !res_ready) begin
                    err_ovf <= 1'b1;
                end else begin
                    res_valid <= 1'b1;
                    res_pix   <= PIX_W'(head_tag.pix);
                    res_fg    <= FG_W'(head_tag.fg);
                end
            end else if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end
        end
    end

`ifdef MAC_SCHED_PERF_EN
    logic stall_cyc;

    assign stall_cyc = (state == ISSUE) && ((rd_req && !rd_gnt) || tag_stall);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else if (start_acc) begin
            perf_busy_cyc  <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (busy && !(&perf_busy_cyc)) begin
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            end
            if (stall_cyc && !(&perf_stall_cyc)) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
        end
    end
`endif

endmodule
